chrom_serial_loader: RTL and testbench

CHROM_SERIAL_LOADER -- requirements
Module: chrom_serial_loader

---
 rtl/chrom_pkg.sv | 18 +
 rtl/chrom_serial_loader.sv | 155 +++++++++++++++
 tb/tb_chrom_serial_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chrom_pkg.sv
// Shared definitions for the chromosome loader and the evaluation top.
//   CHROM_W : chromosome width in bits
//   BYTE_W  : width of one serial transfer
//   N_BYTES : bytes per frame, ceil(CHROM_W/BYTE_W)
//   loader_state_t : loader FSM state encoding
package chrom_pkg;

  localparam int CHROM_W = 260;
  localparam int BYTE_W  = 8;
  localparam int N_BYTES = (CHROM_W + BYTE_W - 1) / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } loader_state_t;

endpackage

// File: rtl/chrom_serial_loader.sv
// Byte-serial chromosome loader with double buffering.
// A frame is N_BYTES bytes, byte 0 flagged by in_sof, little-endian by byte.
// Bytes collect in a shadow register; a complete, well-formed frame is copied
// into cromossomo in one step, so the evaluation circuit never sees a partial
// chromosome.
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   in_valid     : upstream byte present
//   in_sof       : present byte is byte 0 of a frame
//   in_data      : upstream byte
//   in_ready     : byte accepted this cycle when in_valid is also high
//   cromossomo   : active chromosome
//   chrom_valid  : at least one frame committed since reset
//   chrom_update : one-cycle pulse after cromossomo changes
//   frame_err    : one-cycle pulse on an aborted or malformed frame
//   err_count    : saturating frame error count
module chrom_serial_loader
  import chrom_pkg::*;
#(
  parameter int CHROM_W = chrom_pkg::CHROM_W,
  parameter int N_BYTES = chrom_pkg::N_BYTES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [BYTE_W-1:0]   in_data,
  output logic                in_ready,
  output logic [CHROM_W-1:0]  cromossomo,
  output logic                chrom_valid,
  output logic                chrom_update,
  output logic                frame_err,
  output logic [7:0]          err_count
);

  localparam int CNT_W  = $clog2(N_BYTES + 1);
  // Number of meaningful bits in the last byte of a frame.
  localparam int TAIL_W = CHROM_W - BYTE_W * (N_BYTES - 1);
  // Bits of the last byte that lie beyond the chromosome and must be zero.
  localparam logic [BYTE_W-1:0] PAD_MASK = BYTE_W'({BYTE_W{1'b1}} << TAIL_W);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_BYTES - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  loader_state_t        state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 acc;
  logic                 wr_en;
  logic [CNT_W-1:0]     wr_idx;
  logic                 err_set;
  logic                 commit;
  logic [CHROM_W-1:0]   shadow;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc       = in_valid && in_ready;
    wr_en     = 1'b0;
    wr_idx    = cnt;
    err_set   = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        // Bytes outside a frame are dropped silently until a start byte.
        if (acc && in_sof) begin
          wr_en     = 1'b1;
          wr_idx    = '0;
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (acc) begin
          wr_en = 1'b1;
          if (in_sof) begin
            // Unexpected start: report the aborted frame, restart with this byte.
            err_set = 1'b1;
            wr_idx  = '0;
            cnt_nxt = CNT_W'(1);
          end else if (cnt == LAST_IDX) begin
            cnt_nxt = '0;
            if ((in_data & PAD_MASK) != '0) begin
              err_set   = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_COMMIT;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_COMMIT: begin
        commit    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_IDLE, ST_LOAD: in_ready = 1'b1;
      default:          in_ready = 1'b0;
    endcase
  end

  // Shadow buffer: no reset, a fresh frame always starts by overwriting byte 0.
  // The last byte only contributes its TAIL_W low bits.
  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BYTES - 1; b++) begin
      if (wr_en && wr_idx == CNT_W'(b))
        shadow[BYTE_W*b +: BYTE_W] <= in_data;
    end
    if (wr_en && wr_idx == LAST_IDX)
      shadow[CHROM_W-1 : BYTE_W*(N_BYTES-1)] <= in_data[TAIL_W-1:0];
  end

  // Active chromosome and status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cromossomo   <= '0;
      chrom_valid  <= 1'b0;
      chrom_update <= 1'b0;
      frame_err    <= 1'b0;
      err_count    <= '0;
    end else begin
      chrom_update <= commit;
      frame_err    <= err_set;
      if (commit) begin
        cromossomo  <= shadow;
        chrom_valid <= 1'b1;
      end
      if (err_set)
        err_count <= sat_inc8(err_count);
    end
  end

endmodule

// File: tb/tb_chrom_serial_loader.sv
module tb_chrom_serial_loader;

  localparam int CHROM_W = 260;
  localparam int NB      = 33;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_sof;
  logic [7:0]         in_data;
  logic               in_ready;
  logic [CHROM_W-1:0] cromossomo;
  logic               chrom_valid;
  logic               chrom_update;
  logic               frame_err;
  logic [7:0]         err_count;

  chrom_serial_loader #(.CHROM_W(CHROM_W), .N_BYTES(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .cromossomo   (cromossomo),
    .chrom_valid  (chrom_valid),
    .chrom_update (chrom_update),
    .frame_err    (frame_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_err    = 0;
  int  n_upd    = 0;
  int  n_ferr   = 0;
  bit  started  = 0;

  logic [7:0] fr [NB];

  task automatic chk(input string nm, input logic [CHROM_W-1:0] act,
                     input logic [CHROM_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: frame-level view of the stream.
  logic [7:0]         m_fb [NB];
  int                 m_idx;
  bit                 m_inframe;
  bit                 m_pending;
  logic [CHROM_W-1:0] m_chrom;
  bit                 m_valid, m_upd, m_err;
  logic [7:0]         m_errs;

  function automatic logic [CHROM_W-1:0] pack_frame();
    logic [8*NB-1:0] t;
    for (int b = 0; b < NB; b++) t[8*b +: 8] = m_fb[b];
    return t[CHROM_W-1:0];
  endfunction

  task automatic bump();
    m_err = 1;
    if (m_errs != 8'd255) m_errs = m_errs + 8'd1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idx = 0; m_inframe = 0; m_pending = 0; m_chrom = '0;
      m_valid = 0; m_upd = 0; m_err = 0; m_errs = 8'd0;
    end else begin
      m_upd = 0;
      m_err = 0;
      if (m_pending) begin
        m_chrom   = pack_frame();
        m_valid   = 1;
        m_upd     = 1;
        m_pending = 0;
      end else if (in_valid) begin
        if (in_sof) begin
          if (m_inframe) bump();
          m_fb[0]   = in_data;
          m_idx     = 1;
          m_inframe = 1;
        end else if (m_inframe) begin
          m_fb[m_idx] = in_data;
          if (m_idx == NB - 1) begin
            m_inframe = 0;
            if ((in_data >> (CHROM_W - 8*(NB-1))) != 8'd0) bump();
            else m_pending = 1;
          end else begin
            m_idx++;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready",     CHROM_W'(in_ready),     CHROM_W'(!m_pending));
      chk("cromossomo",   cromossomo,             m_chrom);
      chk("chrom_valid",  CHROM_W'(chrom_valid),  CHROM_W'(m_valid));
      chk("chrom_update", CHROM_W'(chrom_update), CHROM_W'(m_upd));
      chk("frame_err",    CHROM_W'(frame_err),    CHROM_W'(m_err));
      chk("err_count",    CHROM_W'(err_count),    CHROM_W'(m_errs));
      if (chrom_update) n_upd++;
      if (frame_err) n_ferr++;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic s);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    guard = 0;
    while (!in_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 8 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int gapmax);
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(0, gapmax)) @(posedge clk);
      send_byte(fr[i], (i == 0));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int u0, e0;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 started = 1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",    CHROM_W'(in_ready),    CHROM_W'(1));
    chk("rst_cromossomo",  cromossomo,            '0);
    chk("rst_chrom_valid", CHROM_W'(chrom_valid), CHROM_W'(0));
    chk("rst_err_count",   CHROM_W'(err_count),   CHROM_W'(0));

    // 1: continuous frame 0x00..0x1F, last byte 0x0A
    for (int i = 0; i < NB; i++) fr[i] = 8'(i);
    fr[NB-1] = 8'h0A;
    u0 = n_upd;
    send_range(0, NB-1, 0);
    idle(3);
    chk("t1_byte0",   CHROM_W'(cromossomo[7:0]),     CHROM_W'(8'h00));
    chk("t1_byte1",   CHROM_W'(cromossomo[15:8]),    CHROM_W'(8'h01));
    chk("t1_tail",    CHROM_W'(cromossomo[259:256]), CHROM_W'(4'hA));
    chk("t1_valid",   CHROM_W'(chrom_valid),         CHROM_W'(1));
    chk("t1_updates", CHROM_W'(n_upd - u0),          CHROM_W'(1));

    // 2: same frame with gaps, then all-ones frame; hold until its commit
    send_range(0, NB-1, 3);
    idle(3);
    for (int i = 0; i < NB; i++) fr[i] = 8'hFF;
    fr[NB-1] = 8'h0F;
    u0 = n_upd;
    send_range(0, 19, 2);
    chk("t2_hold_byte1", CHROM_W'(cromossomo[15:8]), CHROM_W'(8'h01));
    chk("t2_hold_upd",   CHROM_W'(n_upd - u0),       CHROM_W'(0));
    send_range(20, NB-1, 2);
    idle(3);
    chk("t2_all_ones", cromossomo,            {CHROM_W{1'b1}});
    chk("t2_updates",  CHROM_W'(n_upd - u0),  CHROM_W'(1));

    // 3: start byte again at byte 10, then a full valid frame
    for (int i = 0; i < NB; i++) fr[i] = 8'(i);
    u0 = n_upd; e0 = n_ferr;
    send_range(0, 9, 0);
    for (int i = 0; i < NB; i++) fr[i] = 8'(i*3 + 1);
    fr[NB-1] = 8'h05;
    send_range(0, NB-1, 0);
    idle(3);
    chk("t3_err_count", CHROM_W'(err_count),         CHROM_W'(1));
    chk("t3_err_pulse", CHROM_W'(n_ferr - e0),       CHROM_W'(1));
    chk("t3_updates",   CHROM_W'(n_upd - u0),        CHROM_W'(1));
    chk("t3_byte1",     CHROM_W'(cromossomo[15:8]),  CHROM_W'(8'h04));
    chk("t3_tail",      CHROM_W'(cromossomo[259:256]), CHROM_W'(4'h5));

    // 4: last byte 0x1A has a padding bit set
    for (int i = 0; i < NB; i++) fr[i] = 8'h55;
    fr[NB-1] = 8'h1A;
    u0 = n_upd; e0 = n_ferr;
    send_range(0, NB-1, 1);
    idle(3);
    chk("t4_err_count", CHROM_W'(err_count),        CHROM_W'(2));
    chk("t4_err_pulse", CHROM_W'(n_ferr - e0),      CHROM_W'(1));
    chk("t4_updates",   CHROM_W'(n_upd - u0),       CHROM_W'(0));
    chk("t4_byte1",     CHROM_W'(cromossomo[15:8]), CHROM_W'(8'h04));

    // 5: reset at byte 20, then a full frame
    for (int i = 0; i < NB; i++) fr[i] = 8'(i);
    fr[NB-1] = 8'h0A;
    send_range(0, 19, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_cromossomo", cromossomo,             '0);
    chk("t5_valid",      CHROM_W'(chrom_valid),  CHROM_W'(0));
    chk("t5_update",     CHROM_W'(chrom_update), CHROM_W'(0));
    chk("t5_frame_err",  CHROM_W'(frame_err),    CHROM_W'(0));
    chk("t5_err_count",  CHROM_W'(err_count),    CHROM_W'(0));
    chk("t5_in_ready",   CHROM_W'(in_ready),     CHROM_W'(1));
    u0 = n_upd;
    send_range(0, NB-1, 0);
    idle(3);
    chk("t5_valid_after", CHROM_W'(chrom_valid),      CHROM_W'(1));
    chk("t5_byte1_after", CHROM_W'(cromossomo[15:8]), CHROM_W'(8'h01));
    chk("t5_updates",     CHROM_W'(n_upd - u0),       CHROM_W'(1));

    // 6: 300 aborted frames (each new start byte aborts the previous frame)
    e0 = n_ferr;
    for (int k = 0; k < 301; k++) send_byte(8'hAA, 1'b1);
    idle(3);
    chk("t6_err_sat",   CHROM_W'(err_count),   CHROM_W'(255));
    chk("t6_err_pulse", CHROM_W'(n_ferr - e0), CHROM_W'(300));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
